// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the register file and its selectors.
// Holds the Y86 register encodings, the default widths, the instruction
// codes used by the SRC/DEST selectors, and the address-validity helper.
package reg_file_mp_pkg;

  localparam int unsigned DefDataWid = 64;
  localparam int unsigned DefAddrWid = 4;

  // Register encodings
  localparam logic [3:0] rax_    = 4'h0;
  localparam logic [3:0] rcx_    = 4'h1;
  localparam logic [3:0] rdx_    = 4'h2;
  localparam logic [3:0] rbx_    = 4'h3;
  localparam logic [3:0] rsp_    = 4'h4;
  localparam logic [3:0] rbp_    = 4'h5;
  localparam logic [3:0] rsi_    = 4'h6;
  localparam logic [3:0] rdi_    = 4'h7;
  localparam logic [3:0] r8_     = 4'h8;
  localparam logic [3:0] r9_     = 4'h9;
  localparam logic [3:0] r10_    = 4'hA;
  localparam logic [3:0] r11_    = 4'hB;
  localparam logic [3:0] r12_    = 4'hC;
  localparam logic [3:0] r13_    = 4'hD;
  localparam logic [3:0] r14_    = 4'hE;
  localparam logic [3:0] NonReg_ = 4'hF;

  // Instruction codes
  localparam logic [3:0] _HALT  = 4'h0;
  localparam logic [3:0] _NOP   = 4'h1;
  localparam logic [3:0] _RRMOV = 4'h2;
  localparam logic [3:0] _IRMOV = 4'h3;
  localparam logic [3:0] _RMMOV = 4'h4;
  localparam logic [3:0] _MRMOV = 4'h5;
  localparam logic [3:0] _OPQ   = 4'h6;
  localparam logic [3:0] _JXX   = 4'h7;
  localparam logic [3:0] _CALL  = 4'h8;
  localparam logic [3:0] _RET   = 4'h9;
  localparam logic [3:0] _PUSH  = 4'hA;
  localparam logic [3:0] _POP   = 4'hB;

  // An address names a real register only if it is below nreg and is not
  // the all-ones "no register" code.
  function automatic logic addr_valid(input logic [31:0] addr, input int unsigned nreg,
                                      input int unsigned aw);
    return (addr < nreg) && (addr != ((32'd1 << aw) - 32'd1));
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of reg_file_mp.
// Ports:
//   regs       flattened register array, register i in [i*DATA_WID +: DATA_WID]
//   src        read address
//   byp_en     bypass qualifier (write enable and out of reset)
//   dest_e/val_e, dest_m/val_m   same-cycle write ports, used only when BYPASS=1
//   val        read data; 0 for an unimplemented or all-ones address
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_WID = DefDataWid,
  parameter int unsigned ADDR_WID = DefAddrWid,
  parameter int unsigned NREG     = 15,
  parameter int unsigned BYPASS   = 0
) (
  input  logic [NREG*DATA_WID-1:0] regs,
  input  logic [ADDR_WID-1:0]      src,
  input  logic                     byp_en,
  input  logic [ADDR_WID-1:0]      dest_e,
  input  logic [DATA_WID-1:0]      val_e,
  input  logic [ADDR_WID-1:0]      dest_m,
  input  logic [DATA_WID-1:0]      val_m,
  output logic [DATA_WID-1:0]      val
);

  localparam bit BypassEn = (BYPASS != 0);

  logic [DATA_WID-1:0] stored;
  logic                hit_e;
  logic                hit_m;

  // Equality decode: out-of-range and all-ones addresses match nothing and read 0.
  always_comb begin
    stored = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (src == ADDR_WID'(i)) stored = regs[i*DATA_WID +: DATA_WID];
    end
  end

  assign hit_m = byp_en && addr_valid(32'(dest_m), NREG, ADDR_WID) && (src == dest_m);
  assign hit_e = byp_en && addr_valid(32'(dest_e), NREG, ADDR_WID) && (src == dest_e);

  // M over E, matching the write priority.
  always_comb begin
    val = stored;
    if (BypassEn && hit_m) begin
      val = val_m;
    end else if (BypassEn && hit_e) begin
      val = val_e;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file for decode/writeback.
// Ports:
//   CLK         writes commit on the rising edge
//   RST_N       asynchronous active-low reset; clears the array, RSP_IDX loads RSP_INIT
//   WE          global write enable (0 = stall)
//   srcR/valR   NUM_RD packed read address / data ports
//   destE/valE  E write port (ALU result)
//   destM/valM  M write port (memory result); wins over E on the same register
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_WID = DefDataWid,
  parameter int unsigned ADDR_WID = DefAddrWid,
  parameter int unsigned NREG     = 15,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 0,
  parameter int unsigned RSP_IDX  = 4,
  parameter logic [DATA_WID-1:0] RSP_INIT = '0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         WE,
  input  logic [NUM_RD*ADDR_WID-1:0]   srcR,
  output logic [NUM_RD*DATA_WID-1:0]   valR,
  input  logic [ADDR_WID-1:0]          destE,
  input  logic [DATA_WID-1:0]          valE,
  input  logic [ADDR_WID-1:0]          destM,
  input  logic [DATA_WID-1:0]          valM
);

  logic [DATA_WID-1:0]      regs_q [NREG];
  logic [DATA_WID-1:0]      regs_d [NREG];
  logic [NREG*DATA_WID-1:0] regs_flat;
  logic                     we_e;
  logic                     we_m;

  assign we_e = WE && addr_valid(32'(destE), NREG, ADDR_WID);
  assign we_m = WE && addr_valid(32'(destM), NREG, ADDR_WID);

  // M is applied after E so it wins when both target the same register.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (we_e && (destE == ADDR_WID'(i))) regs_d[i] = valE;
      if (we_m && (destM == ADDR_WID'(i))) regs_d[i] = valM;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_flat[i*DATA_WID +: DATA_WID] = regs_q[i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(
      .DATA_WID (DATA_WID),
      .ADDR_WID (ADDR_WID),
      .NREG     (NREG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .regs   (regs_flat),
      .src    (srcR[k*ADDR_WID +: ADDR_WID]),
      .byp_en (WE & RST_N),
      .dest_e (destE),
      .val_e  (valE),
      .dest_m (destM),
      .val_m  (valM),
      .val    (valR[k*DATA_WID +: DATA_WID])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (no bypass / bypass) sharing stimulus,
// checked against an array model on every negative edge plus literal checks.
module tb_reg_file_mp;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NR = 15;
  localparam int NP = 3;
  localparam logic [63:0] RSPI = 64'h100;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            we;
  logic [NP*AW-1:0] src;
  logic [NP*DW-1:0] val0;
  logic [NP*DW-1:0] val1;
  logic [3:0]      dest_e;
  logic [3:0]      dest_m;
  logic [63:0]     val_e;
  logic [63:0]     val_m;

  logic [63:0] model [NR];
  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_WID(DW), .ADDR_WID(AW), .NREG(NR), .NUM_RD(NP), .BYPASS(0),
                .RSP_IDX(4), .RSP_INIT(RSPI)) dut0 (
    .CLK(clk), .RST_N(rst_n), .WE(we), .srcR(src), .valR(val0),
    .destE(dest_e), .valE(val_e), .destM(dest_m), .valM(val_m)
  );

  reg_file_mp #(.DATA_WID(DW), .ADDR_WID(AW), .NREG(NR), .NUM_RD(NP), .BYPASS(1),
                .RSP_IDX(4), .RSP_INIT(RSPI)) dut1 (
    .CLK(clk), .RST_N(rst_n), .WE(we), .srcR(src), .valR(val1),
    .destE(dest_e), .valE(val_e), .destM(dest_m), .valM(val_m)
  );

  function automatic bit vld(input logic [3:0] a);
    return (a != 4'hF) && (int'(a) < NR);
  endfunction

  // What a read port must show right now, given the model and live inputs.
  function automatic logic [63:0] expect_rd(input logic [3:0] s, input bit byp);
    if (byp && rst_n && we && vld(dest_m) && s == dest_m) return val_m;
    if (byp && rst_n && we && vld(dest_e) && s == dest_e) return val_e;
    if (vld(s)) return model[s];
    return 64'd0;
  endfunction

  function automatic logic [63:0] rdv(input int d, input int k);
    return (d == 0) ? val0[k*DW +: DW] : val1[k*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = (i == 4) ? RSPI : 64'd0;
  endtask

  task automatic model_commit();
    if (rst_n && we) begin
      if (vld(dest_e)) model[dest_e] = val_e;
      if (vld(dest_m)) model[dest_m] = val_m;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_src(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    src = {c, b, a};
  endtask

  task automatic wr(input bit w, input logic [3:0] e, input logic [63:0] ve,
                    input logic [3:0] m, input logic [63:0] vm);
    we = w; dest_e = e; val_e = ve; dest_m = m; val_m = vm;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NP; k++) begin
        chk($sformatf("cyc_nobyp_p%0d", k), rdv(0, k), expect_rd(src[k*AW +: AW], 1'b0));
        chk($sformatf("cyc_byp_p%0d", k), rdv(1, k), expect_rd(src[k*AW +: AW], 1'b1));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wr(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    set_src(4'd0, 4'd4, 4'hF);
    model_reset();
    cmp_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("reset_r0", rdv(0, 0), 64'd0);
    chk("reset_rsp", rdv(0, 1), 64'h100);
    chk("reset_nonreg", rdv(1, 2), 64'd0);
    step();

    // E write to rax; bypass shows it same cycle, no-bypass shows old value
    wr(1'b1, 4'd0, 64'd3, 4'hF, 64'd0);
    set_src(4'd0, 4'd0, 4'd0);
    #1;
    chk("rax_pre_nobyp", rdv(0, 0), 64'd0);
    chk("rax_pre_byp", rdv(1, 0), 64'd3);
    step();
    we = 1'b0;
    #1;
    chk("rax_post", rdv(0, 0), 64'd3);

    // Both ports to rsp: M wins
    wr(1'b1, 4'd4, 64'd56, 4'd4, 64'd21);
    set_src(4'd4, 4'd4, 4'd4);
    #1;
    chk("popq_byp", rdv(1, 1), 64'd21);
    chk("popq_pre_nobyp", rdv(0, 1), 64'h100);
    step();
    we = 1'b0;
    #1;
    chk("popq_post", rdv(0, 2), 64'd21);

    // Two different registers in one edge, duplicate read addresses
    wr(1'b1, 4'd1, 64'd7, 4'd2, 64'd15);
    step();
    we = 1'b0;
    set_src(4'd1, 4'd2, 4'd1);
    #1;
    chk("dual_p0", rdv(0, 0), 64'd7);
    chk("dual_p1", rdv(0, 1), 64'd15);
    chk("dual_p2", rdv(1, 2), 64'd7);

    // Stall: no write, no bypass
    wr(1'b0, 4'd3, 64'd9, 4'hF, 64'd0);
    set_src(4'd3, 4'd3, 4'd3);
    #1;
    chk("stall_byp", rdv(1, 0), 64'd0);
    step();
    chk("stall_post", rdv(0, 0), 64'd0);

    // No-register address writes nothing
    wr(1'b1, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 64'hDEAD);
    step();
    we = 1'b0;
    set_src(4'hF, 4'd4, 4'd0);
    #1;
    chk("nonreg_read", rdv(1, 0), 64'd0);
    chk("nonreg_rsp", rdv(0, 1), 64'd21);
    chk("nonreg_rax", rdv(0, 2), 64'd3);

    // Asynchronous reset mid-cycle after writes
    set_src(4'd0, 4'd4, 4'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rax", rdv(0, 0), 64'd0);
    chk("async_rsp", rdv(0, 1), 64'h100);
    chk("async_rcx", rdv(1, 2), 64'd0);
    wr(1'b1, 4'd0, 64'd5, 4'hF, 64'd0);
    #1;
    chk("async_byp_off", rdv(1, 0), 64'd0);
    step();

    // Write coinciding with reset is dropped; lands after release
    wr(1'b1, 4'd5, 64'd77, 4'hF, 64'd0);
    set_src(4'd5, 4'd5, 4'd5);
    step();
    rst_n = 1'b1;
    we = 1'b0;
    #1;
    chk("rst_write_drop", rdv(0, 0), 64'd0);
    step();
    wr(1'b1, 4'd5, 64'd77, 4'hF, 64'd0);
    step();
    we = 1'b0;
    #1;
    chk("rst_write_after", rdv(0, 1), 64'd77);

    // Randomized traffic with forced collisions
    for (int n = 0; n < 600; n++) begin
      logic [3:0] a [NP];
      we = ($urandom_range(0, 4) != 0);
      dest_e = 4'($urandom_range(0, 15));
      dest_m = ($urandom_range(0, 3) == 0) ? dest_e : 4'($urandom_range(0, 15));
      val_e = {$urandom, $urandom};
      val_m = {$urandom, $urandom};
      for (int k = 0; k < NP; k++) begin
        case ($urandom_range(0, 3))
          0: a[k] = dest_e;
          1: a[k] = dest_m;
          default: a[k] = 4'($urandom_range(0, 15));
        endcase
      end
      set_src(a[0], a[1], a[2]);
      step();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
